// File: rtl/fp_add_sequencer.sv
// Operand feeder for the FP adder: queues operand pairs, issues them over the
// adder's start/done handshake, holds each sum for the consumer, and watchdogs the adder.
module fp_add_sequencer #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic [EXP_W+MAN_W:0]     add_a,
  output logic [EXP_W+MAN_W:0]     add_b,
  output logic                     add_start,
  input  logic                     add_done,
  input  logic [EXP_W+MAN_W:0]     add_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [7:0]               out_cycles,
  output logic                     err_timeout
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [W-1:0]    mem_a [DEPTH];
  logic [W-1:0]    mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [WD_W-1:0] wd;
  logic [7:0]      cyc;

  logic push, pop, capture, expire, empty;

  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign capture  = (state == WAIT_DONE) && add_done;
  // Expiry only counts when the edge being waited for has not arrived this cycle.
  assign expire   = (wd == WD_LAST) &&
                    (((state == WAIT_BUSY) && add_done) ||
                     ((state == WAIT_DONE) && !add_done));
  assign pop      = capture || expire;

  assign add_a = empty ? '0 : mem_a[rd_ptr];
  assign add_b = empty ? '0 : mem_b[rd_ptr];

  // NOTE: the storage array carries no reset; an empty FIFO masks its contents,
  // so resetting it would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wd          <= '0;
      cyc         <= '0;
      add_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_cycles  <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (out_valid && out_ready) out_valid <= 1'b0;
      add_start <= 1'b0;

      case (state)
        IDLE: begin
          if (!empty && !out_valid && add_done) begin
            state     <= ISSUE;
            add_start <= 1'b1;
          end
        end
        ISSUE: begin
          // The cycle counter includes the ISSUE cycle itself.
          wd    <= '0;
          cyc   <= 8'd1;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (wd != WD_LAST) wd <= wd + 1'b1;
          cyc <= (cyc == 8'hFF) ? cyc : cyc + 8'd1;
          if (capture) begin
            out_data   <= add_res;
            out_valid  <= 1'b1;
            out_cycles <= cyc;
            state      <= IDLE;
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else if ((state == WAIT_BUSY) && !add_done) begin
            state <= WAIT_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural adder (lookup-table sums,
// programmable busy latency, optional never-responding mode).
module tb_fp_add_sequencer;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] add_a, add_b, add_res;
  logic         add_start, add_done;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [7:0]   out_cycles;
  logic         err_timeout;

  fp_add_sequencer #(.EXP_W(8), .MAN_W(23), .DEPTH(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_done(add_done), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cycles(out_cycles),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } vec_t;
  vec_t vecs [10];

  int checks = 0;
  int errors = 0;
  logic [W-1:0] got [$];
  logic [W-1:0] exp_q [$];
  int starts = 0;

  function automatic logic [W-1:0] fp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 10; i++)
      if (vecs[i].a == a && vecs[i].b == b) return vecs[i].sum;
    return 32'hDEADBEEF;
  endfunction

  // Behavioural adder: done high while idle, low for 'lat' cycles after sampling start.
  int           lat = 6;
  bit           stuck = 1'b0;
  logic         busy = 1'b0;
  int           left = 0;
  logic [W-1:0] res_q = '0;
  assign add_done = !busy;
  assign add_res  = res_q;

  always @(posedge CLK) begin
    if (rst) begin
      busy <= 1'b0;
      left <= 0;
    end else if (!busy && add_start && !stuck) begin
      busy  <= 1'b1;
      left  <= lat;
      res_q <= fp_sum(add_a, add_b);
    end else if (busy) begin
      if (left == 1) busy <= 1'b0;
      left <= left - 1;
    end
  end

  always @(negedge CLK) if (add_start) starts++;

  always begin
    @(negedge CLK);
    #2;
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return add_done;
      1:       return out_valid;
      2:       return add_start;
      default: return err_timeout;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int limit,
                          input string name, output int t);
    t = 0;
    while (sig(sel) !== lvl && t < limit) begin
      @(negedge CLK);
      t++;
    end
    check(name, {31'd0, sig(sel)}, {31'd0, lvl});
  endtask

  task automatic push_vec(input int i, input bit expect_it);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready got 0, required 1");
    end else begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      @(negedge CLK);
      in_valid = 1'b0;
      if (expect_it) exp_q.push_back(vecs[i].sum);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (got.size() < exp_q.size() && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    int s0;
    logic [W-1:0] held;

    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000}; // 1 + 2 = 3
    vecs[1] = '{32'h3F800000, 32'h3F800000, 32'h40000000}; // 1 + 1 = 2
    vecs[2] = '{32'h40000000, 32'h40000000, 32'h40800000}; // 2 + 2 = 4
    vecs[3] = '{32'h3F800000, 32'hBF800000, 32'h00000000}; // 1 + -1 = 0
    vecs[4] = '{32'h40400000, 32'h3F800000, 32'h40800000}; // 3 + 1 = 4
    vecs[5] = '{32'h3F000000, 32'h3F000000, 32'h3F800000}; // .5 + .5 = 1
    vecs[6] = '{32'h40000000, 32'hBF000000, 32'h3FC00000}; // 2 + -.5 = 1.5
    vecs[7] = '{32'h40800000, 32'h40800000, 32'h41000000}; // 4 + 4 = 8
    vecs[8] = '{32'h41200000, 32'h3F800000, 32'h41300000}; // 10 + 1 = 11
    vecs[9] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000}; // 1.5 + 1.5 = 3

    // Reset state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    starts = 0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_add_start", {31'd0, add_start}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_cycles", {24'd0, out_cycles}, 32'd0);
    check("rst_add_a", add_a, 32'd0);

    // Single operation, latency 6
    out_ready = 1'b1;
    push_vec(0, 1'b1);
    drain("single");
    check("single_cycles", {24'd0, out_cycles}, 32'd7);
    check("single_starts", 32'(starts), 32'd1);
    check("single_empty", add_a, 32'd0);
    check("single_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back pushes fill the FIFO
    push_vec(1, 1'b1);
    push_vec(2, 1'b1);
    push_vec(3, 1'b1);
    check("fill3_in_ready", {31'd0, in_ready}, 32'd1);
    push_vec(4, 1'b1);
    check("fill4_in_ready", {31'd0, in_ready}, 32'd0);
    push_vec(5, 1'b1);
    drain("burst");

    // Backpressure holds the result and blocks issue
    out_ready = 1'b0;
    push_vec(6, 1'b1);
    push_vec(7, 1'b1);
    wait_for(1, 1'b1, 100, "bp_valid", t);
    check("bp_data", out_data, vecs[6].sum);
    held = out_data;
    s0 = starts;
    tick(20);
    check("bp_data_held", out_data, held);
    check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    check("bp_no_start", 32'(starts), 32'(s0));
    out_ready = 1'b1;
    wait_for(2, 1'b1, 10, "bp_reissue", t);
    check("bp_reissue_delay", 32'(t), 32'd2);
    drain("bp");

    // Done arriving on the watchdog's last cycle wins
    lat = 63;
    push_vec(8, 1'b1);
    drain("late_done");
    check("late_done_cycles", {24'd0, out_cycles}, 32'd64);
    check("late_done_err", {31'd0, err_timeout}, 32'd0);
    lat = 6;

    // Adder never answers: watchdog drops the pair
    stuck = 1'b1;
    push_vec(9, 1'b0);
    wait_for(2, 1'b1, 10, "to_start", t);
    wait_for(3, 1'b1, 200, "to_err_set", t);
    check("to_cycles", 32'(t), 32'd65);
    check("to_out_valid", {31'd0, out_valid}, 32'd0);
    check("to_dropped", add_a, 32'd0);
    stuck = 1'b0;
    push_vec(0, 1'b1);
    drain("after_to");
    check("to_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset mid-operation with pairs queued
    push_vec(1, 1'b0);
    push_vec(2, 1'b0);
    push_vec(3, 1'b0);
    wait_for(0, 1'b0, 20, "mid_busy", t);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err", {31'd0, err_timeout}, 32'd0);
    check("mid_rst_start", {31'd0, add_start}, 32'd0);
    check("mid_rst_empty", add_a, 32'd0);
    s0 = starts;
    tick(10);
    check("mid_rst_no_start", 32'(starts), 32'(s0));
    check("mid_rst_no_result", 32'(got.size()), 32'd0);
    got.delete();
    exp_q.delete();

    // Push and pop on the same edge at count == DEPTH-1, then wrap across 8 ops
    push_vec(0, 1'b1);
    push_vec(1, 1'b1);
    push_vec(2, 1'b1);
    wait_for(0, 1'b0, 20, "pp_busy", t);
    wait_for(0, 1'b1, 20, "pp_done", t);
    push_vec(3, 1'b1);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    push_vec(4, 1'b1);
    check("pp_full", {31'd0, in_ready}, 32'd0);
    push_vec(5, 1'b1);
    push_vec(6, 1'b1);
    push_vec(7, 1'b1);
    drain("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Upstream operand feeder for the floating-point adder datapath/controller pair. Buffers operand pairs arriving on a valid/ready stream and issues each pair to the adder through its start/done handshake. Captures each sum into a held output register with valid/ready. Flags an adder that stops answering with a watchdog timeout.

Parameters:
EXP_W, 8, exponent width of the packed operand {sign, exp, man}
MAN_W, 23, stored mantissa width
DEPTH, 4, operand-pair FIFO entries; power of two, at least 2
TIMEOUT, 64, maximum cycles spent waiting on the adder per operation; at least 4

Ports:
CLK  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair present on in_a/in_b
in_ready  out  1  FIFO can accept a pair; equals !full
in_a  in  W=1+EXP_W+MAN_W  operand A {sign, exp, man}
in_b  in  W  operand B
add_a  out  W  operand A to adder; FIFO head, held stable until pop
add_b  out  W  operand B to adder; FIFO head
add_start  out  1  start request to adder
add_done  in  1  adder done; high while the adder is idle
add_res  in  W  adder result {sign, exp, man}
out_valid  out  1  result held in out_data
out_ready  in  1  consumer accepts the result
out_data  out  W  captured sum
out_cycles  out  8  cycles from ISSUE to capture, saturating at 255
err_timeout  out  1  sticky; set by a watchdog expiry, cleared only by rst

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation): FSM goes to IDLE, FIFO is emptied (pointers and count = 0), add_start=0, out_valid=0, out_data=0, out_cycles=0, err_timeout=0, watchdog=0. The adder must be reset in the same cycle at system level.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on capture or on timeout.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - in_ready=0 when count==DEPTH, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - add_a/add_b always show the head entry, or 0 when empty.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count!=0 && !out_valid && add_done, go to ISSUE. Otherwise stay.
  - ISSUE: add_start=1 for exactly one cycle. Watchdog and cycle counter are cleared. Go to WAIT_BUSY.
  - WAIT_BUSY: add_start=0. Wait for add_done==0, which means the adder has left its idle state and latched the operands; then go to WAIT_DONE. The head entry is not popped here, so operands stay stable through the adder's load cycle.
  - WAIT_DONE: wait for add_done==1. On that edge: out_data<=add_res, out_valid<=1, out_cycles<=counter, pop the FIFO, go to IDLE.
- Watchdog:
  - Increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT-1 without the awaited edge: set err_timeout, pop (drop) the pair, leave out_valid unchanged, go to IDLE.
  - If add_done arrives in the same cycle as expiry, the done edge wins (normal capture, no error).
- Output:
  - out_valid falls on the cycle after out_valid && out_ready.
  - out_data and out_cycles are stable while out_valid=1.
  - A new issue is blocked while out_valid=1, so a result is never overwritten.
  - If out_ready is asserted in the same cycle as the IDLE check, that check still sees out_valid=1; issue happens one cycle later.
- Minimum throughput: one result per (adder latency + 3) cycles.
- No arithmetic on operands: pass-through only.

Test Plan:
1. Reset, push A=0x3F800000, B=0x40000000 with the bench adder model (latency 6) → add_start pulses once; out_data=0x40400000, out_valid=1, out_cycles=adder latency+1, FIFO empty.
2. Push 5 pairs back-to-back with out_ready=1, DEPTH=4 → in_ready drops after the 4th push. All 5 results emerge in order, e.g. 1+1=0x40000000, 2+2=0x40800000, 1+(-1)=0x00000000.
3. Hold out_ready=0 after the first result → no second add_start; out_data is unchanged across 20 cycles. Raising out_ready → the next issue follows in 2 cycles.
4. Adder model never drops add_done after start → after TIMEOUT=64 cycles err_timeout=1, the pair is dropped, the next pair issues normally, and err_timeout stays 1.
5. Assert rst during WAIT_DONE with 3 pairs queued → next cycle: IDLE, in_ready=1, out_valid=0, err_timeout=0, no add_start.
6. Simultaneous push and pop at count==DEPTH-1 → count unchanged; the pointer wrap at DEPTH preserves order across 8 consecutive operations.
